// File: rtl/uart_msg_sequencer.sv
// Streams an N-byte message buffer into the uart transmit handshake, one-shot or periodic.
// Optional UART_MSG_CRLF_EN appends 8'h0D 8'h0A to every message.
module uart_msg_sequencer #(
    parameter int MSG_DEPTH     = 16,
    parameter int ADDR_W        = 4,
    parameter int PERIOD_CYCLES = 2097152,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [7:0]        cfg_wdata,
    input  logic [ADDR_W:0]   msg_len,
    input  logic              periodic_en,
    input  logic              start,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  msg_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        STROBE,
        WAIT_HI,
        WAIT_LO,
        FINISH
    } state_t;

    localparam int PW = $clog2(PERIOD_CYCLES);
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MSG_DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    logic [7:0]        mem [MSG_DEPTH];
    logic [7:0]        rd_q;
    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len;
    logic [PW-1:0]     per_cnt;
    logic              pend;
    logic              per_hit;
    logic              req;
    logic              last;
    logic [ADDR_W:0]   lat_len;

`ifdef UART_MSG_CRLF_EN
    // 0: buffer bytes, 1: CR, 2: LF
    logic [1:0] term;
`endif

    assign per_hit = periodic_en && (per_cnt == PER_LAST);
    assign req     = periodic_en ? per_hit : start;
    assign lat_len = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
    assign last    = ({1'b0, idx} == (len - LEN_ONE));

    always_ff @(posedge clk) begin
        if (cfg_we) begin
            mem[cfg_addr] <= cfg_wdata;
        end
        rd_q <= mem[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            len       <= '0;
            per_cnt   <= '0;
            pend      <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            msg_count <= '0;
`ifdef UART_MSG_CRLF_EN
            term      <= 2'd0;
`endif
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;

            if (periodic_en) begin
                per_cnt <= per_hit ? '0 : per_cnt + PW'(1);
            end else begin
                per_cnt <= '0;
            end

            unique case (state)
                IDLE: begin
                    // one request may wait here for the uart to go idle
                    if ((pend || req) && !tx_busy) begin
                        pend <= 1'b0;
                        len  <= lat_len;
                        busy <= 1'b1;
                        idx  <= '0;
                        if (lat_len == '0) begin
`ifdef UART_MSG_CRLF_EN
                            term  <= 2'd1;
                            state <= FETCH;
`else
                            state <= FINISH;
`endif
                        end else begin
                            state <= FETCH;
                        end
                    end else if (req) begin
                        pend <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= STROBE;
                end
                STROBE: begin
`ifdef UART_MSG_CRLF_EN
                    if (term == 2'd1) begin
                        tx_data <= 8'h0D;
                    end else if (term == 2'd2) begin
                        tx_data <= 8'h0A;
                    end else begin
                        tx_data <= rd_q;
                    end
`else
                    tx_data <= rd_q;
`endif
                    tx_start <= 1'b1;
                    state    <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
`ifdef UART_MSG_CRLF_EN
                        if (term == 2'd2) begin
                            term  <= 2'd0;
                            state <= FINISH;
                        end else if (term == 2'd1) begin
                            term  <= 2'd2;
                            state <= FETCH;
                        end else if (last) begin
                            term  <= 2'd1;
                            idx   <= '0;
                            state <= FETCH;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= FETCH;
                        end
`else
                        if (last) begin
                            idx   <= '0;
                            state <= FINISH;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= FETCH;
                        end
`endif
                    end
                end
                FINISH: begin
                    done      <= 1'b1;
                    msg_count <= msg_count + CNT_W'(1);
                    idx       <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Randomized bench for uart_msg_sequencer with a uart busy responder
// and a queue-based model of the expected byte stream.
module tb_uart_msg_sequencer;

    localparam int DEPTH    = 16;
    localparam int AW       = 4;
    localparam int PER      = 200;
    localparam int CW       = 8;
    localparam int BUSY_CYC = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [7:0]    cfg_wdata = '0;
    logic [AW:0]   msg_len = '0;
    logic          periodic_en = 1'b0;
    logic          start = 1'b0;
    logic          tx_busy;
    logic          uart_busy = 1'b0;
    logic          force_busy = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          busy;
    logic          done;
    logic [CW-1:0] msg_count;

    int total = 0;
    int bad = 0;
    int n_start = 0;
    int n_done = 0;
    int bcnt = 0;
    byte unsigned mem_m [DEPTH];
    byte unsigned got_q [$];
    byte unsigned exp_q [$];
    logic [CW-1:0] exp_cnt = '0;

    assign tx_busy = uart_busy | force_busy;

    always #5 clk = ~clk;

    uart_msg_sequencer #(
        .MSG_DEPTH(DEPTH),
        .ADDR_W(AW),
        .PERIOD_CYCLES(PER),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .msg_len(msg_len),
        .periodic_en(periodic_en),
        .start(start),
        .tx_busy(tx_busy),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .busy(busy),
        .done(done),
        .msg_count(msg_count)
    );

    // uart stand-in: busy for BUSY_CYC cycles after each strobe
    always @(negedge clk) begin
        if (!rst_n) begin
            uart_busy = 1'b0;
            bcnt = 0;
        end else begin
            if (done) n_done++;
            if (tx_start) begin
                got_q.push_back(tx_data);
                n_start++;
                uart_busy = 1'b1;
                bcnt = BUSY_CYC;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) uart_busy = 1'b0;
            end
        end
    end

    function automatic int eff_len(input int l);
        return (l > DEPTH) ? DEPTH : l;
    endfunction

    task automatic build_exp(input int l);
        exp_q.delete();
        for (int i = 0; i < eff_len(l); i++) exp_q.push_back(mem_m[i]);
`ifdef UART_MSG_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic wr(input int a, input byte unsigned d);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = AW'(a);
        cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic pulse_start(input int l);
        @(negedge clk);
        msg_len = (AW+1)'(l);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while ((busy || tx_busy) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        total++;
        if (busy || tx_busy) begin
            bad++;
            $display("FAIL %s idle: busy=%0b required 0 (timeout)", nm, busy);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total += 5;
        if (tx_start !== 1'b0) begin
            bad++; $display("FAIL rst tx_start: got %b want 0", tx_start);
        end
        if (tx_data !== 8'h00) begin
            bad++; $display("FAIL rst tx_data: got %h want 00", tx_data);
        end
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rst busy: got %b want 0", busy);
        end
        if (done !== 1'b0) begin
            bad++; $display("FAIL rst done: got %b want 0", done);
        end
        if (msg_count !== '0) begin
            bad++; $display("FAIL rst msg_count: got %0d want 0", msg_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_hi();
        int s0, d0;
        wr(0, 8'h48);
        wr(1, 8'h69);
        wr(2, 8'h21);
        s0 = got_q.size();
        d0 = n_done;
        pulse_start(3);
        wait_idle("hi");
        build_exp(3);
        exp_cnt++;
        total += 3;
        if (got_q.size() - s0 != exp_q.size()) begin
            bad++;
            $display("FAIL hi nbytes: got %0d want %0d", got_q.size() - s0, exp_q.size());
        end
        if (n_done - d0 != 1) begin
            bad++; $display("FAIL hi done: got %0d want 1", n_done - d0);
        end
        if (msg_count !== exp_cnt) begin
            bad++; $display("FAIL hi msg_count: got %0d want %0d", msg_count, exp_cnt);
        end
        for (int i = 0; i < exp_q.size() && s0 + i < got_q.size(); i++) begin
            total++;
            if (got_q[s0+i] !== exp_q[i]) begin
                bad++;
                $display("FAIL hi byte%0d: got %h want %h", i, got_q[s0+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_len(input string nm, input int l);
        int s0, d0;
        s0 = got_q.size();
        d0 = n_done;
        pulse_start(l);
        wait_idle(nm);
        build_exp(l);
        exp_cnt++;
        total += 3;
        if (got_q.size() - s0 != exp_q.size()) begin
            bad++;
            $display("FAIL %s nbytes: got %0d want %0d", nm, got_q.size() - s0, exp_q.size());
        end
        if (n_done - d0 != 1) begin
            bad++; $display("FAIL %s done: got %0d want 1", nm, n_done - d0);
        end
        if (msg_count !== exp_cnt) begin
            bad++; $display("FAIL %s msg_count: got %0d want %0d", nm, msg_count, exp_cnt);
        end
        for (int i = 0; i < exp_q.size() && s0 + i < got_q.size(); i++) begin
            total++;
            if (got_q[s0+i] !== exp_q[i]) begin
                bad++;
                $display("FAIL %s byte%0d: got %h want %h", nm, i, got_q[s0+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_len_zero();
        test_len("len0", 0);
    endtask

    task automatic test_clamp();
        for (int a = 0; a < DEPTH; a++) wr(a, 8'($urandom_range(0, 255)));
        test_len("clamp", 31);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < DEPTH; a++) wr(a, 8'($urandom_range(0, 255)));
            test_len("rand", $urandom_range(0, 20));
        end
    endtask

    task automatic test_back_to_back();
        int s0, d0;
        s0 = got_q.size();
        d0 = n_done;
        pulse_start(3);
        repeat (4) @(negedge clk);
        pulse_start(3);
        wait_idle("b2b");
        build_exp(3);
        exp_cnt++;
        total += 3;
        if (got_q.size() - s0 != exp_q.size()) begin
            bad++;
            $display("FAIL b2b nbytes: got %0d want %0d", got_q.size() - s0, exp_q.size());
        end
        if (n_done - d0 != 1) begin
            bad++; $display("FAIL b2b done: got %0d want 1", n_done - d0);
        end
        if (msg_count !== exp_cnt) begin
            bad++; $display("FAIL b2b msg_count: got %0d want %0d", msg_count, exp_cnt);
        end
    endtask

    task automatic test_busy_hold();
        int s0, d0, k;
        s0 = got_q.size();
        d0 = n_done;
        force_busy = 1'b1;
        pulse_start(2);
        repeat (50) @(negedge clk);
        total += 2;
        if (got_q.size() != s0) begin
            bad++; $display("FAIL hold early_strobe: got %0d want 0", got_q.size() - s0);
        end
        if (busy !== 1'b0) begin
            bad++; $display("FAIL hold busy: got %b want 0", busy);
        end
        force_busy = 1'b0;
        k = 0;
        while (!busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        wait_idle("hold");
        build_exp(2);
        exp_cnt++;
        total += 2;
        if (got_q.size() - s0 != exp_q.size()) begin
            bad++;
            $display("FAIL hold nbytes: got %0d want %0d", got_q.size() - s0, exp_q.size());
        end
        if (msg_count !== exp_cnt) begin
            bad++; $display("FAIL hold msg_count: got %0d want %0d", msg_count, exp_cnt);
        end
        for (int i = 0; i < exp_q.size() && s0 + i < got_q.size(); i++) begin
            total++;
            if (got_q[s0+i] !== exp_q[i]) begin
                bad++;
                $display("FAIL hold byte%0d: got %h want %h", i, got_q[s0+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_periodic();
        int s0, d0, n_msg, run;
        run = 1100;
        n_msg = run / PER;
        build_exp(2);
        s0 = got_q.size();
        d0 = n_done;
        @(negedge clk);
        msg_len = (AW+1)'(2);
        periodic_en = 1'b1;
        repeat (run) @(negedge clk);
        periodic_en = 1'b0;
        wait_idle("per");
        exp_cnt = exp_cnt + CW'(n_msg);
        total += 3;
        if (n_done - d0 != n_msg) begin
            bad++; $display("FAIL per done: got %0d want %0d", n_done - d0, n_msg);
        end
        if (msg_count !== exp_cnt) begin
            bad++; $display("FAIL per msg_count: got %0d want %0d", msg_count, exp_cnt);
        end
        if (got_q.size() - s0 != n_msg * exp_q.size()) begin
            bad++;
            $display("FAIL per nbytes: got %0d want %0d",
                     got_q.size() - s0, n_msg * exp_q.size());
        end
        for (int i = 0; i < n_msg * exp_q.size() && s0 + i < got_q.size(); i++) begin
            total++;
            if (got_q[s0+i] !== exp_q[i % exp_q.size()]) begin
                bad++;
                $display("FAIL per byte%0d: got %h want %h",
                         i, got_q[s0+i], exp_q[i % exp_q.size()]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int s0, k;
        for (int a = 0; a < 4; a++) wr(a, 8'($urandom_range(1, 255)));
        s0 = got_q.size();
        pulse_start(4);
        k = 0;
        while (got_q.size() < s0 + 2 && k < 500) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (got_q.size() < s0 + 2) begin
            bad++; $display("FAIL mid reach_byte2: got %0d want 2", got_q.size() - s0);
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total += 4;
        if (tx_data !== 8'h00) begin
            bad++; $display("FAIL mid tx_data: got %h want 00", tx_data);
        end
        if (busy !== 1'b0) begin
            bad++; $display("FAIL mid busy: got %b want 0", busy);
        end
        if (msg_count !== '0) begin
            bad++; $display("FAIL mid msg_count: got %0d want 0", msg_count);
        end
        if (tx_start !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL mid strobes: got %b%b want 00", tx_start, done);
        end
        exp_cnt = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_len("mid_resend", 4);
    endtask

    task automatic test_wrap();
        int k;
        k = 0;
        while (exp_cnt != {CW{1'b1}} && k < 300) begin
            pulse_start(0);
            wait_idle("wrap_fill");
            exp_cnt++;
            k++;
        end
        total++;
        if (msg_count !== {CW{1'b1}}) begin
            bad++; $display("FAIL wrap top: got %0d want %0d", msg_count, {CW{1'b1}});
        end
        pulse_start(0);
        wait_idle("wrap");
        exp_cnt++;
        total++;
        if (msg_count !== exp_cnt) begin
            bad++; $display("FAIL wrap zero: got %0d want %0d", msg_count, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_hi();
        test_len_zero();
        test_clamp();
        test_random();
        test_back_to_back();
        test_busy_hold();
        test_periodic();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
